ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_if.sv | 15 +
 rtl/ex_muldiv.sv | 90 +++++++++
 tb/tb_ex_muldiv.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage request and HI/LO result bundle for the iterative multiply/divide unit.
interface ex_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  modport master (output start, op, srca, srcb, flush, input hi, lo, busy, done, div_by_zero);
  modport slave  (input start, op, srca, srcb, flush, output hi, lo, busy, done, div_by_zero);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: 32-iteration MULT/MULTU/DIV/DIVU unit writing HI/LO; MULDIV_FAST_MULT_EN enables a single-cycle multiply path.
module ex_muldiv (
    input logic clk,
    input logic rst,
    ex_muldiv_if.slave m
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_n;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic        accept, in_sgn, q_sgn, q_div, fast_mul;
    logic [31:0] ma, mb, q_mag, r_mag, res_hi, res_lo;
    logic [32:0] t, r, rs;
    logic        ge;
    logic [63:0] mul_n, div_n, mul_res;
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
    assign accept = (state == IDLE) && m.start && !m.flush;
    assign in_sgn = !m.op[0];
    assign q_sgn  = !op_q[0];
    assign q_div  = op_q[1];
    assign ma     = mag(a_q, q_sgn);
    assign mb     = mag(b_q, q_sgn);
    // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign t      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    assign mul_n  = {t, acc[31:1]};
    // Restoring divide: bring the next dividend bit into the remainder, subtract the divisor if it fits.
    assign r      = acc[63:31];
    assign ge     = r >= {1'b0, mb};
    assign rs     = r - {1'b0, mb};
    assign div_n  = {ge ? rs[31:0] : r[31:0], acc[30:0], ge};
`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] full;
    assign full     = q_sgn ? 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}))
                            : {32'd0, a_q} * {32'd0, b_q};
    assign fast_mul = !m.op[1];
    assign mul_res  = full;
`else
    assign fast_mul = 1'b0;
    assign mul_res  = (q_sgn && (a_q[31] ^ b_q[31])) ? -acc : acc;
`endif
    assign q_mag  = (q_sgn && (a_q[31] ^ b_q[31])) ? -acc[31:0] : acc[31:0];
    assign r_mag  = (q_sgn && a_q[31]) ? -acc[63:32] : acc[63:32];
    assign res_hi = !q_div ? mul_res[63:32] : (b_q == 32'd0) ? a_q : r_mag;
    assign res_lo = !q_div ? mul_res[31:0]  : (b_q == 32'd0) ? 32'hFFFF_FFFF : q_mag;
    assign m.busy = state != IDLE;
    always_comb begin
        state_n = m.flush ? IDLE :
                  (state == IDLE) ? (m.start ? (fast_mul ? FIN : RUN) : IDLE) :
                  (state == RUN)  ? ((cnt == 5'd31) ? FIN : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= 2'd0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            cnt           <= 5'd0;
            acc           <= 64'd0;
            m.hi          <= 32'd0;
            m.lo          <= 32'd0;
            m.done        <= 1'b0;
            m.div_by_zero <= 1'b0;
        end else begin
            m.done        <= 1'b0;
            m.div_by_zero <= 1'b0;
            if (accept) begin
                op_q <= m.op;
                a_q  <= m.srca;
                b_q  <= m.srcb;
                cnt  <= 5'd0;
                acc  <= {32'd0, m.op[1] ? mag(m.srca, in_sgn) : mag(m.srcb, in_sgn)};
            end else if (state == RUN && !m.flush) begin
                acc <= q_div ? div_n : mul_n;
                cnt <= cnt + 5'd1;
            end else if (state == FIN && !m.flush) begin
                m.hi          <= res_hi;
                m.lo          <= res_lo;
                m.done        <= 1'b1;
                m.div_by_zero <= q_div && (b_q == 32'd0);
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv; expected HI/LO/flag pushed on issue, popped on done.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ex_muldiv_if bus();
    ex_muldiv dut (.clk(clk), .rst(rst), .m(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0]  op;
        logic [64:0] r;
    } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb2;
        logic [63:0] p, q, r;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        if (op[1] && b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        case (op)
            2'd0: p = sa * sb2;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin q = sa / sb2; r = sa % sb2; p = {r[31:0], q[31:0]}; end
            default: p = {a % b, a / b};
        endcase
        return {1'b0, p};
    endfunction
    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int lat, exp_lat;
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        sb.push_back('{op, model(op, a, b)});
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
`ifdef MULDIV_FAST_MULT_EN
        exp_lat = e.op[1] ? 33 : 1;
`else
        exp_lat = 33;
`endif
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("hi", {32'd0, bus.hi}, {32'd0, e.r[63:32]});
        chk("lo", {32'd0, bus.lo}, {32'd0, e.r[31:0]});
        chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.r[64]});
    endtask
    initial begin
        int dones;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.srca  = 32'd0;
        bus.srcb  = 32'd0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;
        run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd0, 32'hFFFF_FFFD, 32'd7);
        run(2'd0, 32'h8000_0000, 32'h8000_0000);
        run(2'd2, 32'hFFFF_FFF9, 32'd2);
        run(2'd3, 32'd7, 32'd2);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd3, 32'd5, 32'd0);
        run(2'd2, 32'hFFFF_FF00, 32'd0);
        for (int i = 0; i < 8; i++)
            run(2'($urandom_range(0, 3)), $urandom, (i % 2) ? 32'($urandom_range(1, 300)) : $urandom);
        run(2'd1, 32'h8000_0001, 32'd2);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.srca  = 32'd9;
        bus.srcb  = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.srca  = 32'd3;
        bus.srcb  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_before_flush", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("busy_after_flush", {63'd0, bus.busy}, 64'd0);
        chk("flush_hi", {32'd0, bus.hi}, 64'd1);
        chk("flush_lo", {32'd0, bus.lo}, 64'd2);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("flush_no_done", 64'(dones), 64'd0);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_beats_start", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.srca  = 32'hFFFF_FFF9;
        bus.srcb  = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_hi", {32'd0, bus.hi}, 64'd0);
        chk("arst_lo", {32'd0, bus.lo}, 64'd0);
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        #1 rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("arst_no_done", 64'(dones), 64'd0);
        run(2'd3, 32'd100, 32'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
